// File: rtl/interleave_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// interleave_buffer_ctrl
//
// Streaming, double-buffered interleaver for the turbo decoder SISO loop.
// Soft values arrive in natural order, one per accepted beat. Each block of N
// values is stored in one of two banks. While a full bank drains, the other
// bank can fill. A bank drains in one of two orders:
//   mode 0 (interleave)    : output j = input (j+1)   mod N
//   mode 1 (de-interleave) : output j = input (j+N-1) mod N
// Mode 1 undoes mode 0.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : asynchronous reset, active-high
//   mode       : permutation select, captured on the first write of a block
//   in_valid   : in_data is valid
//   in_ready   : a write is accepted this cycle (registered-state only)
//   in_data    : soft value in natural order (W bits)
//   out_valid  : out_data is valid (registered-state only)
//   out_ready  : downstream takes out_data this cycle
//   out_data   : permuted soft value (W bits)
//   out_last   : out_data is the final symbol of its block
//   busy       : a bank is full or a block is partially written
// -----------------------------------------------------------------------------
module interleave_buffer_ctrl #(
   parameter int N = 10,
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         mode,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         out_last,
   output logic         busy
);

   localparam int IW = (N > 2) ? $clog2(N) : 1;
   localparam logic [IW-1:0] IDX_ZERO = {IW{1'b0}};
   localparam logic [IW-1:0] IDX_ONE  = IW'(1);
   localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

   // Storage and control state
   logic [W-1:0]  bank_q [2][N];
   logic [1:0]    full_q, full_d;
   logic [1:0]    bank_mode_q, bank_mode_d;
   logic          wr_bank_q, wr_bank_d;
   logic          rd_bank_q, rd_bank_d;
   logic [IW-1:0] wr_idx_q, wr_idx_d;
   logic [IW-1:0] rd_idx_q, rd_idx_d;

   logic          in_ready_s;
   logic          out_valid_s;
   logic          wr_fire_s;
   logic          rd_fire_s;
   logic [IW-1:0] src_s;

   // Handshake strobes; ready/valid depend on registered flags only
   always_comb begin
      in_ready_s  = ~full_q[wr_bank_q];
      out_valid_s = full_q[rd_bank_q];
      wr_fire_s   = in_valid & in_ready_s;
      rd_fire_s   = out_valid_s & out_ready;
   end

   // Next-state logic for write/read pointers, full flags and bank modes.
   // A write needs !full and a read needs full, so the two never touch the
   // same bank in one cycle and their full-flag updates cannot collide.
   always_comb begin
      full_d      = full_q;
      bank_mode_d = bank_mode_q;
      wr_bank_d   = wr_bank_q;
      rd_bank_d   = rd_bank_q;
      wr_idx_d    = wr_idx_q;
      rd_idx_d    = rd_idx_q;

      if (wr_fire_s) begin
         if (wr_idx_q == IDX_ZERO) begin
            bank_mode_d[wr_bank_q] = mode;
         end else begin
            bank_mode_d = bank_mode_q;
         end
         if (wr_idx_q == IDX_LAST) begin
            wr_idx_d          = IDX_ZERO;
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
         end else begin
            wr_idx_d = wr_idx_q + IDX_ONE;
         end
      end else begin
         wr_idx_d = wr_idx_q;
      end

      if (rd_fire_s) begin
         if (rd_idx_q == IDX_LAST) begin
            rd_idx_d          = IDX_ZERO;
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
         end else begin
            rd_idx_d = rd_idx_q + IDX_ONE;
         end
      end else begin
         rd_idx_d = rd_idx_q;
      end
   end

   // Source index within the draining bank: compare-and-wrap rotation
   always_comb begin
      if (bank_mode_q[rd_bank_q] == 1'b0) begin
         if (rd_idx_q == IDX_LAST) begin
            src_s = IDX_ZERO;
         end else begin
            src_s = rd_idx_q + IDX_ONE;
         end
      end else begin
         if (rd_idx_q == IDX_ZERO) begin
            src_s = IDX_LAST;
         end else begin
            src_s = rd_idx_q - IDX_ONE;
         end
      end
   end

   // State registers and bank storage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_q      <= 2'b00;
         bank_mode_q <= 2'b00;
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         wr_idx_q    <= IDX_ZERO;
         rd_idx_q    <= IDX_ZERO;
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < N; i++) begin
               bank_q[b][i] <= {W{1'b0}};
            end
         end
      end else begin
         full_q      <= full_d;
         bank_mode_q <= bank_mode_d;
         wr_bank_q   <= wr_bank_d;
         rd_bank_q   <= rd_bank_d;
         wr_idx_q    <= wr_idx_d;
         rd_idx_q    <= rd_idx_d;
         if (wr_fire_s) begin
            bank_q[wr_bank_q][wr_idx_q] <= in_data;
         end
      end
   end

   // Output decode from registered state only
   always_comb begin
      in_ready  = in_ready_s;
      out_valid = out_valid_s;
      out_data  = bank_q[rd_bank_q][src_s];
      out_last  = out_valid_s & (rd_idx_q == IDX_LAST);
      busy      = full_q[0] | full_q[1] | (wr_idx_q != IDX_ZERO);
   end

endmodule
